// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the sequential divider.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
//
// Contents: div_state_t (IDLE/RUN/SIGN), DIV_ITERS, DIV_CNT_W,
// condNeg() for the two's-complement magnitude and sign-fix steps.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } div_state_t;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 5;

    // Two's-complement negate when neg is set. Wraps, so the magnitude of
    // 0x80000000 stays 0x80000000, which the datapath treats as unsigned.
    function automatic logic [31:0] condNeg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Start/done handshake bundle between the control FSM and the divider.
// Latency: wires only.
// Backpressure: none; the divider ignores start while busy.
//
// Signals: start, a, b (control -> divider); lo, hi, busy, done,
// div_zero (divider -> control). With DIV_DIVU_EN defined, is_unsigned is
// added in the control -> divider direction.
interface div_unit_if #(parameter int DATA_W = 32);

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    logic              busy;
    logic              done;
    logic              div_zero;
`ifdef DIV_DIVU_EN
    logic              is_unsigned;

    modport master (
        output start, a, b, is_unsigned,
        input  lo, hi, busy, done, div_zero
    );

    modport slave (
        input  start, a, b, is_unsigned,
        output lo, hi, busy, done, div_zero
    );
`else
    modport master (
        output start, a, b,
        input  lo, hi, busy, done, div_zero
    );

    modport slave (
        input  start, a, b,
        output lo, hi, busy, done, div_zero
    );
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
// Latency: combinational.
// Backpressure: not applicable.
//
// Inputs: rem (partial remainder), dvdMsb (next dividend bit), divisor.
// Outputs: remNext (updated partial remainder), qBit (quotient bit).
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dvdMsb,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] remNext,
    output logic              qBit
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] trial;

    // The shifted remainder needs one extra bit: rem < divisor, so
    // shifted < 2*divisor, which can exceed 32 bits for large divisors.
    assign shifted = {rem, dvdMsb};

    // Subtraction succeeds when shifted >= divisor; the wide compare stands in
    // for the borrow of the trial subtraction.
    assign qBit  = (shifted >= {1'b0, divisor});

    // On success the true difference is below divisor, so the low word is exact.
    assign trial   = shifted[DATA_W-1:0] - divisor;
    assign remNext = qBit ? trial : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit divider (div, optionally divu): quotient to lo, remainder to hi.
// Latency: done pulses 34 cycles after the accept edge; div_zero pulses 1 cycle after.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
//
// Ports: clk, reset (async, active-low), bus (div_unit_if.slave:
// start/a/b in, lo/hi/busy/done/div_zero out).
// Optional feature macro: DIV_DIVU_EN adds bus.is_unsigned (divu semantics).
module div_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic     clk,
    input  logic     reset,
    div_unit_if.slave bus
);

    div_state_t           state;
    div_state_t           nextState;
    logic [DIV_CNT_W-1:0] count;

    logic [DATA_W-1:0] dvdReg;      // dividend magnitude, becomes the quotient
    logic [DATA_W-1:0] remReg;
    logic [DATA_W-1:0] divisorReg;
    logic              qNeg;
    logic              rNeg;
    logic [DATA_W-1:0] loReg;
    logic [DATA_W-1:0] hiReg;
    logic              busyReg;
    logic              doneReg;
    logic              divZeroReg;

    logic              accept;
    logic              zeroReq;
    logic              signedOp;
    logic              aNeg;
    logic              bNeg;
    logic [DATA_W-1:0] stepRem;
    logic              stepQBit;

`ifdef DIV_DIVU_EN
    assign signedOp = ~bus.is_unsigned;
`else
    assign signedOp = 1'b1;
`endif

    // For divu both sign flags stay clear, which bypasses abs and sign-fix.
    assign aNeg = signedOp & bus.a[DATA_W-1];
    assign bNeg = signedOp & bus.b[DATA_W-1];

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem     (remReg),
        .dvdMsb  (dvdReg[DATA_W-1]),
        .divisor (divisorReg),
        .remNext (stepRem),
        .qBit    (stepQBit)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        zeroReq   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0) begin
                        zeroReq = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        nextState = RUN;
                    end
                end
            end
            RUN: begin
                if (count == DIV_CNT_W'(DIV_ITERS - 1)) begin
                    nextState = SIGN;
                end
            end
            SIGN: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            dvdReg     <= '0;
            remReg     <= '0;
            divisorReg <= '0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            loReg      <= '0;
            hiReg      <= '0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
        end else begin
            doneReg    <= 1'b0;
            divZeroReg <= zeroReq;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvdReg     <= condNeg(bus.a, aNeg);
                        divisorReg <= condNeg(bus.b, bNeg);
                        remReg     <= '0;
                        count      <= '0;
                        qNeg       <= aNeg ^ bNeg;
                        rNeg       <= aNeg;
                        busyReg    <= 1'b1;
                    end
                end
                RUN: begin
                    // Dividend bits leave at the top while quotient bits
                    // enter at the bottom of the same register.
                    dvdReg <= {dvdReg[DATA_W-2:0], stepQBit};
                    remReg <= stepRem;
                    count  <= count + DIV_CNT_W'(1);
                end
                SIGN: begin
                    loReg   <= condNeg(dvdReg, qNeg);
                    hiReg   <= condNeg(remReg, rNeg);
                    doneReg <= 1'b1;
                    busyReg <= 1'b0;
                end
                default: begin
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lo       = loReg;
    assign bus.hi       = hiReg;
    assign bus.busy     = busyReg;
    assign bus.done     = doneReg;
    assign bus.div_zero = divZeroReg;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at stimulus time,
// compared when done/div_zero appear.
// Runs in the default build; divu cases are added when DIV_DIVU_EN is defined.
module tb_div_unit;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    div_unit_if ifc();

    div_unit dut (
        .clk   (clk),
        .reset (rstN),
        .bus   (ifc)
    );

    typedef struct packed {
        logic        isZero;
        logic [31:0] lo;
        logic [31:0] hi;
    } expT;

    expT sb[$];
    int  compared   = 0;
    int  mismatched = 0;
    logic [31:0] lastLo = '0;
    logic [31:0] lastHi = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: truncating division on magnitudes, quotient sign = sign(a)^sign(b),
    // remainder sign = sign(a). Returns {lo, hi}.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic        aN, bN;
        logic [31:0] ua, ub, q, r;
        aN = !uns && a[31];
        bN = !uns && b[31];
        ua = aN ? (32'd0 - a) : a;
        ub = bN ? (32'd0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        return {((aN ^ bN) ? (32'd0 - q) : q), (aN ? (32'd0 - r) : r)};
    endfunction

    // Result monitor: every done/div_zero pulse must match the queue head.
    always @(negedge clk) begin
        expT e;
        if (rstN && (ifc.done || ifc.div_zero)) begin
            if (sb.size() == 0) begin
                check("unexpectedEvent", {ifc.done, ifc.div_zero}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("evtKind", {ifc.done, ifc.div_zero}, e.isZero ? 64'd1 : 64'd2);
                check("sbLo", ifc.lo, e.lo);
                check("sbHi", ifc.hi, e.hi);
            end
        end
    end

    // Drives one request at a negedge and waits for its completion.
    // injectAt >= 0 raises a stray start that cycle to prove it is ignored.
    task automatic doDiv(input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input int injectAt);
        logic [63:0] res;
        int cyc;
        int busyCnt;
        ifc.start = 1'b1;
        ifc.a     = a;
        ifc.b     = b;
`ifdef DIV_DIVU_EN
        ifc.is_unsigned = uns;
`endif
        if (b == 32'd0) begin
            sb.push_back({1'b1, lastLo, lastHi});
        end else begin
            res = model(a, b, uns);
            sb.push_back({1'b0, res[63:32], res[31:0]});
            lastLo = res[63:32];
            lastHi = res[31:0];
        end
        @(posedge clk);                 // accept edge E0
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.a     = $urandom;           // operands must already be captured
        ifc.b     = $urandom;
        if (b == 32'd0) begin
            check("dzBusy", ifc.busy, 0);
            check("dzPulse", ifc.div_zero, 1);
            @(negedge clk);
            check("dzPulseLen", ifc.div_zero, 0);
            repeat (40) @(negedge clk);
            check("dzBusyLater", ifc.busy, 0);
            check("dzLoKept", ifc.lo, lastLo);
            check("dzHiKept", ifc.hi, lastHi);
        end else begin
            busyCnt = ifc.busy ? 1 : 0;
            cyc     = 0;
            while (1) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (ifc.done) break;
                if (ifc.busy) busyCnt++;
                if (cyc >= 60) begin
                    check("doneTimeout", 0, 1);
                    break;
                end
                if (cyc == injectAt) begin
                    ifc.start = 1'b1;
                    ifc.a     = 32'd1;
                    ifc.b     = 32'd1;
                end else begin
                    ifc.start = 1'b0;
                end
            end
            ifc.start = 1'b0;
            // done visible after E33: 33 edges past E0, i.e. the 34th cycle.
            check("latency", cyc, 33);
            check("busyCycles", busyCnt, 33);
            check("busyLowAtDone", ifc.busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        ifc.start = 1'b0;
        ifc.a     = '0;
        ifc.b     = '0;
`ifdef DIV_DIVU_EN
        ifc.is_unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rstLo", ifc.lo, 0);
        check("rstHi", ifc.hi, 0);
        check("rstBusy", ifc.busy, 0);
        check("rstDone", ifc.done, 0);
        check("rstDivZero", ifc.div_zero, 0);
        rstN = 1'b1;
        @(negedge clk);

        doDiv(32'd100, 32'd7, 1'b0, -1);
        check("lo_100_7", ifc.lo, 32'd14);
        check("hi_100_7", ifc.hi, 32'd2);

        // Back-to-back: issued at the negedge where done is high.
        doDiv(32'hFFFFFF9C, 32'd7, 1'b0, -1);
        check("lo_m100_7", ifc.lo, 32'hFFFFFFF2);
        check("hi_m100_7", ifc.hi, 32'hFFFFFFFE);

        doDiv(32'd100, 32'hFFFFFFF9, 1'b0, -1);
        check("lo_100_m7", ifc.lo, 32'hFFFFFFF2);
        check("hi_100_m7", ifc.hi, 32'd2);

        doDiv(32'd5, 32'd0, 1'b0, -1);

        doDiv(32'h80000000, 32'hFFFFFFFF, 1'b0, 9);
        check("lo_min_m1", ifc.lo, 32'h80000000);
        check("hi_min_m1", ifc.hi, 32'd0);
        repeat (3) @(negedge clk);
        check("lo_min_m1_kept", ifc.lo, 32'h80000000);

        doDiv(32'h7FFFFFFF, 32'h80000000, 1'b0, -1);
        check("lo_max_min", ifc.lo, 32'd0);
        check("hi_max_min", ifc.hi, 32'h7FFFFFFF);

        doDiv(32'h80000000, 32'h80000000, 1'b0, -1);
        check("lo_min_min", ifc.lo, 32'd1);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            if (rb == 32'd0) rb = 32'd3;
            doDiv(ra, rb, 1'b0, -1);
        end

        // Abort mid-operation with reset; no result may appear for it.
        ifc.start = 1'b1;
        ifc.a     = 32'd1000;
        ifc.b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (11) @(negedge clk);
        rstN = 1'b0;
        #1;
        check("abortLo", ifc.lo, 0);
        check("abortHi", ifc.hi, 0);
        check("abortBusy", ifc.busy, 0);
        check("abortDone", ifc.done, 0);
        check("abortDivZero", ifc.div_zero, 0);
        @(negedge clk);
        rstN   = 1'b1;
        lastLo = '0;
        lastHi = '0;

        doDiv(32'd9, 32'd3, 1'b0, -1);
        check("lo_9_3", ifc.lo, 32'd3);
        check("hi_9_3", ifc.hi, 32'd0);

`ifdef DIV_DIVU_EN
        doDiv(32'hFFFFFFFF, 32'd2, 1'b1, -1);
        check("lo_divu", ifc.lo, 32'h7FFFFFFF);
        check("hi_divu", ifc.hi, 32'd1);
        doDiv(32'hFFFFFFFF, 32'd2, 1'b0, -1);
        check("lo_div_m1_2", ifc.lo, 32'd0);
        check("hi_div_m1_2", ifc.hi, 32'hFFFFFFFF);
`endif

        repeat (40) @(negedge clk);
        check("sbEmpty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
